// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the CP0 system-control block.
//   - CP0 register numbers used by MTC0/MFC0 decode
//   - ExcCode values
//   - Status/Cause bit positions
//   - default exception vector
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_BD     = 31;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0180;

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer with clock prescaler.
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_we_count          MTC0 to Count: reload Count, restart prescaler
//   i_we_compare        MTC0 to Compare: load Compare, clear pending
//   i_data              MTC0 write data
//   o_count, o_compare  live register values
//   o_timer_pending     set when Count steps onto Compare
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we_count,
  input  logic        i_we_compare,
  input  logic [31:0] i_data,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_timer_pending
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [31:0]   r_count;
  logic [31:0]   r_compare;
  logic          r_pending;
  logic          w_tick;
  logic [31:0]   w_count_inc;

  assign w_tick      = (r_presc == PS_LAST);
  assign w_count_inc = r_count + 32'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc   <= '0;
      r_count   <= '0;
      r_compare <= 32'hFFFF_FFFF;
      r_pending <= 1'b0;
    end else begin
      if (i_we_count) begin
        r_count <= i_data;
        r_presc <= '0;
      end else if (w_tick) begin
        r_presc <= '0;
        r_count <= w_count_inc;
        if (w_count_inc == r_compare) r_pending <= 1'b1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      // A Compare write acknowledges the timer even if a match lands this cycle.
      if (i_we_compare) begin
        r_compare <= i_data;
        r_pending <= 1'b0;
      end
    end
  end

  assign o_count         = r_count;
  assign o_compare       = r_compare;
  assign o_timer_pending = r_pending;

endmodule

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: CP0 system-control block (Count/Compare, Status, Cause, EPC),
// interrupt masking, exception entry / ERET sequencing and registered PC redirect.
// Optional feature macro: CP0_BADVADDR_EN adds i_bad_vaddr and read-only register 8.
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_we, i_w_reg, i_data_in           MTC0 write port
//   i_r_reg, o_data_out                MFC0 read port (combinational, no bypass)
//   i_exc_valid, i_exc_code,
//   i_exc_pc, i_exc_bd                 exception entry
//   i_eret                             ERET retire
//   i_hw_int                           level external interrupts
//   o_int_req                          pending enabled interrupt
//   o_redirect, o_redirect_pc          1-cycle fetch redirect
//   o_status_out, o_cause_out, o_epc_out  live register values
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter int          NUM_HW_INT = 5,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [4:0]            i_w_reg,
  input  logic [31:0]           i_data_in,
  input  logic [4:0]            i_r_reg,
  output logic [31:0]           o_data_out,
  input  logic                  i_exc_valid,
  input  logic [4:0]            i_exc_code,
  input  logic [31:0]           i_exc_pc,
  input  logic                  i_exc_bd,
  input  logic                  i_eret,
  input  logic [NUM_HW_INT-1:0] i_hw_int,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0]           i_bad_vaddr,
`endif
  output logic                  o_int_req,
  output logic                  o_redirect,
  output logic [31:0]           o_redirect_pc,
  output logic [31:0]           o_status_out,
  output logic [31:0]           o_cause_out,
  output logic [31:0]           o_epc_out
);

  logic        r_ie, r_exl, r_bd;
  logic [7:0]  r_im;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_ip_hw;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;
  logic        r_redirect;
  logic [31:0] r_redirect_pc;

  logic [31:0] w_count, w_compare;
  logic        w_timer_pending;
  logic [7:0]  w_ip;
  logic [31:0] w_status, w_cause;
  logic        w_wr_status, w_wr_cause, w_wr_epc;

  assign w_wr_status = i_we && (i_w_reg == REG_STATUS);
  assign w_wr_cause  = i_we && (i_w_reg == REG_CAUSE);
  assign w_wr_epc    = i_we && (i_w_reg == REG_EPC);

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_we_count     (i_we && (i_w_reg == REG_COUNT)),
    .i_we_compare   (i_we && (i_w_reg == REG_COMPARE)),
    .i_data         (i_data_in),
    .o_count        (w_count),
    .o_compare      (w_compare),
    .o_timer_pending(w_timer_pending)
  );

  // Statement order in the else-branch encodes priority: later writes win,
  // so exception > ERET > MTC0 on shared fields.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ie          <= 1'b0;
      r_exl         <= 1'b0;
      r_bd          <= 1'b0;
      r_im          <= '0;
      r_ip_sw       <= '0;
      r_ip_hw       <= '0;
      r_exccode     <= '0;
      r_epc         <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_ip_hw <= 5'(i_hw_int);
      if (w_wr_status) begin
        r_ie  <= i_data_in[STATUS_IE];
        r_exl <= i_data_in[STATUS_EXL];
        r_im  <= i_data_in[STATUS_IM_LO +: 8];
      end
      if (w_wr_cause) r_ip_sw <= i_data_in[CAUSE_IP_LO +: 2];
      if (w_wr_epc)   r_epc   <= i_data_in;
      if (i_eret)     r_exl   <= 1'b0;
      if (i_exc_valid) begin
        r_exl     <= 1'b1;
        r_exccode <= i_exc_code;
        // Nested exceptions keep the original return point.
        if (!r_exl) begin
          r_epc <= i_exc_bd ? (i_exc_pc - 32'd4) : i_exc_pc;
          r_bd  <= i_exc_bd;
        end
      end
      r_redirect <= i_exc_valid | i_eret;
      if (i_exc_valid)  r_redirect_pc <= EXC_VECTOR;
      else if (i_eret)  r_redirect_pc <= r_epc;
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [31:0] r_badvaddr;
  always_ff @(posedge i_clk) begin
    if (i_rst) r_badvaddr <= '0;
    else if (i_exc_valid && (i_exc_code == EXC_ADEL || i_exc_code == EXC_ADES))
      r_badvaddr <= i_bad_vaddr;
  end
`endif

  assign w_ip = {w_timer_pending, r_ip_hw, r_ip_sw};

  always_comb begin
    w_status = '0;
    w_status[STATUS_IE]         = r_ie;
    w_status[STATUS_EXL]        = r_exl;
    w_status[STATUS_IM_LO +: 8] = r_im;
    w_cause = '0;
    w_cause[CAUSE_BD]           = r_bd;
    w_cause[CAUSE_IP_LO +: 8]   = w_ip;
    w_cause[CAUSE_EXC_LO +: 5]  = r_exccode;
  end

  always_comb begin
    o_data_out = '0;
    case (i_r_reg)
      REG_COUNT:    o_data_out = w_count;
      REG_COMPARE:  o_data_out = w_compare;
      REG_STATUS:   o_data_out = w_status;
      REG_CAUSE:    o_data_out = w_cause;
      REG_EPC:      o_data_out = r_epc;
`ifdef CP0_BADVADDR_EN
      REG_BADVADDR: o_data_out = r_badvaddr;
`endif
      default:      o_data_out = '0;
    endcase
  end

  assign o_int_req     = r_ie & ~r_exl & (|(w_ip & r_im));
  assign o_redirect    = r_redirect;
  assign o_redirect_pc = r_redirect_pc;
  assign o_status_out  = w_status;
  assign o_cause_out   = w_cause;
  assign o_epc_out     = r_epc;

endmodule

// File: tb/tb_cp0_ctrl.sv
module tb_cp0_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  w_reg = '0;
  logic [31:0] data_in = '0;
  logic [4:0]  r_reg = '0;
  logic [31:0] data_out;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_pc = '0;
  logic        exc_bd = 1'b0;
  logic        eret = 1'b0;
  logic [4:0]  hw_int = '0;
  logic        int_req, redirect;
  logic [31:0] redirect_pc, status_out, cause_out, epc_out;
`ifdef CP0_BADVADDR_EN
  logic [31:0] bad_vaddr = '0;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;
  logic [31:0] obs;

  cp0_ctrl #(.NUM_HW_INT(5), .COUNT_DIV(2), .EXC_VECTOR(32'h0000_0180)) dut (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_w_reg(w_reg), .i_data_in(data_in),
    .i_r_reg(r_reg), .o_data_out(data_out), .i_exc_valid(exc_valid),
    .i_exc_code(exc_code), .i_exc_pc(exc_pc), .i_exc_bd(exc_bd), .i_eret(eret),
    .i_hw_int(hw_int),
`ifdef CP0_BADVADDR_EN
    .i_bad_vaddr(bad_vaddr),
`endif
    .o_int_req(int_req), .o_redirect(redirect), .o_redirect_pc(redirect_pc),
    .o_status_out(status_out), .o_cause_out(cause_out), .o_epc_out(epc_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] r, output logic [31:0] v);
    r_reg = r;
    #1;
    v = data_out;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    we = 1'b1; w_reg = r; data_in = d;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    foreach (exp_q[i]) begin end
    rd(5'd9, obs);  exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL reset_count got=%h exp=%h", obs, exp); end
    rd(5'd11, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL reset_compare got=%h exp=%h", obs, exp); end
    rd(5'd12, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL reset_status got=%h exp=%h", obs, exp); end
    rd(5'd13, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL reset_cause got=%h exp=%h", obs, exp); end
    rd(5'd14, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL reset_epc got=%h exp=%h", obs, exp); end
    checks++;
    if (redirect !== 1'b0 || redirect_pc !== 32'h0) begin
      failures++; $display("FAIL reset_redirect got=%b/%h exp=0/0", redirect, redirect_pc);
    end
  endtask

  // COUNT_DIV=2: Count steps on every second edge after the Compare write edge,
  // so Count reaches 5 on edge 10 counting the write edge as edge 1.
  task automatic test_timer();
    mtc0(5'd11, 32'd5);
    for (int i = 0; i < 8; i++) tick();
    exp_q.push_back(32'd4); exp_q.push_back(32'h0);
    rd(5'd9, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL timer_count9 got=%h exp=%h", obs, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'b0, cause_out[15]} !== exp) begin failures++; $display("FAIL timer_early_ip7 got=%b exp=0", cause_out[15]); end
    tick();
    exp_q.push_back(32'd5); exp_q.push_back(32'h1);
    rd(5'd9, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL timer_count10 got=%h exp=%h", obs, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'b0, cause_out[15]} !== exp) begin failures++; $display("FAIL timer_ip7 got=%b exp=1", cause_out[15]); end
    mtc0(5'd11, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front(); checks++;
    if ({31'b0, cause_out[15]} !== exp) begin failures++; $display("FAIL timer_clear got=%b exp=0", cause_out[15]); end
    mtc0(5'd9, 32'h0000_1000);
    exp_q.push_back(32'h0000_1000);
    rd(5'd9, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL count_reload got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_int_mask();
    hw_int = 5'b00001;
    mtc0(5'd12, 32'h0000_0401);
    exp_q.push_back(32'h1);
    exp = exp_q.pop_front(); checks++;
    if ({31'b0, int_req} !== exp) begin failures++; $display("FAIL int_enabled got=%b exp=1", int_req); end
    mtc0(5'd12, 32'h0000_0403);
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front(); checks++;
    if ({31'b0, int_req} !== exp) begin failures++; $display("FAIL int_exl got=%b exp=0", int_req); end
    mtc0(5'd12, 32'h0000_0001);
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front(); checks++;
    if ({31'b0, int_req} !== exp) begin failures++; $display("FAIL int_im2_off got=%b exp=0", int_req); end
    mtc0(5'd12, 32'hFFFF_0401);
    exp_q.push_back(32'h0000_0401);
    exp = exp_q.pop_front(); checks++;
    if (status_out !== exp) begin failures++; $display("FAIL status_mask got=%h exp=%h", status_out, exp); end
    hw_int = 5'b00000;
    tick();
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front(); checks++;
    if ({31'b0, int_req} !== exp) begin failures++; $display("FAIL int_hw_low got=%b exp=0", int_req); end
  endtask

  task automatic test_exception();
    exc_valid = 1'b1; exc_code = 5'd12; exc_pc = 32'h40; exc_bd = 1'b1;
    exp_q.push_back(32'h3C); exp_q.push_back(32'h8000_0030); exp_q.push_back(32'h0000_0403);
    exp_q.push_back(32'h180);
    tick();
    exc_valid = 1'b0; exc_bd = 1'b0;
    exp = exp_q.pop_front(); checks++;
    if (epc_out !== exp) begin failures++; $display("FAIL exc_epc got=%h exp=%h", epc_out, exp); end
    exp = exp_q.pop_front(); checks++;
    if (cause_out !== exp) begin failures++; $display("FAIL exc_cause got=%h exp=%h", cause_out, exp); end
    exp = exp_q.pop_front(); checks++;
    if (status_out !== exp) begin failures++; $display("FAIL exc_status got=%h exp=%h", status_out, exp); end
    exp = exp_q.pop_front(); checks++;
    if (redirect !== 1'b1 || redirect_pc !== exp) begin
      failures++; $display("FAIL exc_redirect got=%b/%h exp=1/%h", redirect, redirect_pc, exp);
    end
    tick();
    checks++;
    if (redirect !== 1'b0) begin failures++; $display("FAIL redirect_pulse got=%b exp=0", redirect); end
  endtask

  task automatic test_nested_eret();
    exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h80; exc_bd = 1'b0;
    exp_q.push_back(32'h3C); exp_q.push_back(32'h8000_0010);
    tick();
    exc_valid = 1'b0;
    exp = exp_q.pop_front(); checks++;
    if (epc_out !== exp) begin failures++; $display("FAIL nested_epc got=%h exp=%h", epc_out, exp); end
    exp = exp_q.pop_front(); checks++;
    if (cause_out !== exp) begin failures++; $display("FAIL nested_cause got=%h exp=%h", cause_out, exp); end
    eret = 1'b1;
    exp_q.push_back(32'h3C); exp_q.push_back(32'h0000_0401);
    tick();
    eret = 1'b0;
    exp = exp_q.pop_front(); checks++;
    if (redirect !== 1'b1 || redirect_pc !== exp) begin
      failures++; $display("FAIL eret_redirect got=%b/%h exp=1/%h", redirect, redirect_pc, exp);
    end
    exp = exp_q.pop_front(); checks++;
    if (status_out !== exp) begin failures++; $display("FAIL eret_status got=%h exp=%h", status_out, exp); end
  endtask

  task automatic test_back_to_back();
    exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h100; exc_bd = 1'b0;
    eret = 1'b1; we = 1'b1; w_reg = 5'd12; data_in = 32'h0000_FF00;
    exp_q.push_back(32'h0000_FF02); exp_q.push_back(32'h180); exp_q.push_back(32'h100);
    tick();
    exc_valid = 1'b0; eret = 1'b0; we = 1'b0;
    exp = exp_q.pop_front(); checks++;
    if (status_out !== exp) begin failures++; $display("FAIL prio_status got=%h exp=%h", status_out, exp); end
    exp = exp_q.pop_front(); checks++;
    if (redirect !== 1'b1 || redirect_pc !== exp) begin
      failures++; $display("FAIL prio_redirect got=%b/%h exp=1/%h", redirect, redirect_pc, exp);
    end
    exp = exp_q.pop_front(); checks++;
    if (epc_out !== exp) begin failures++; $display("FAIL prio_epc got=%h exp=%h", epc_out, exp); end
  endtask

  task automatic test_regfile();
    we = 1'b1; w_reg = 5'd14; data_in = 32'h0000_1234;
    exp_q.push_back(32'h100); exp_q.push_back(32'h0000_1234);
    rd(5'd14, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL no_bypass got=%h exp=%h", obs, exp); end
    tick();
    we = 1'b0;
    rd(5'd14, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL epc_write got=%h exp=%h", obs, exp); end
    mtc0(5'd13, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_0320);
    rd(5'd13, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL cause_sw_ip got=%h exp=%h", obs, exp); end
    mtc0(5'd3, 32'hDEAD_BEEF);
    exp_q.push_back(32'h0);
    rd(5'd3, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL unmapped got=%h exp=%h", obs, exp); end
`ifndef CP0_BADVADDR_EN
    exp_q.push_back(32'h0);
    rd(5'd8, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL badvaddr_off got=%h exp=%h", obs, exp); end
`endif
  endtask

  task automatic test_reset_mid();
    exc_valid = 1'b1; exc_code = 5'd10; exc_pc = 32'h200;
    tick();
    exc_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp = exp_q.pop_front(); checks++;
    if (redirect !== 1'b0 || redirect_pc !== exp) begin
      failures++; $display("FAIL midreset_redirect got=%b/%h exp=0/%h", redirect, redirect_pc, exp);
    end
    exp = exp_q.pop_front(); checks++;
    if (status_out !== exp || cause_out !== exp || epc_out !== exp) begin
      failures++; $display("FAIL midreset_regs got=%h/%h/%h exp=0", status_out, cause_out, epc_out);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_timer();
    test_int_mask();
    test_exception();
    test_nested_eret();
    test_back_to_back();
    test_regfile();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
